citadel_gen: RTL and testbench

- Small command-driven compute engine with a FIFO-style command input and a 32-bit response output.
- Holds four 32-bit operand registers (IN0..IN3) and continuously derives four result values from them through a 2-stage pipeline.
- Host writes operands and fetches results/operands with command structs; read commands return one 32-bit word on the response port.

---
 rtl/citadel_gen_if.sv | 31 +++
 rtl/citadel_gen.sv | 111 +++++++++++
 tb/tb_citadel_gen.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/citadel_gen_if.sv
// rtl/citadel_gen_if.sv - command/response FIFO handshake bundle for citadel_gen
//
// Command side: req/rdata flow host->engine, ack flows back.
// Response side: req/wdata flow engine->host, ack flows back.
// master = host view, slave = engine view.
interface citadel_gen_if;
    logic        cmd_req_genfifo_req_i;
    logic [95:0] cmd_req_genfifo_rdata_bi;
    logic        cmd_req_genfifo_ack_o;
    logic        cmd_resp_genfifo_req_o;
    logic [31:0] cmd_resp_genfifo_wdata_bo;
    logic        cmd_resp_genfifo_ack_i;

    modport master (
        output cmd_req_genfifo_req_i,
        output cmd_req_genfifo_rdata_bi,
        input  cmd_req_genfifo_ack_o,
        input  cmd_resp_genfifo_req_o,
        input  cmd_resp_genfifo_wdata_bo,
        output cmd_resp_genfifo_ack_i
    );

    modport slave (
        input  cmd_req_genfifo_req_i,
        input  cmd_req_genfifo_rdata_bi,
        output cmd_req_genfifo_ack_o,
        output cmd_resp_genfifo_req_o,
        output cmd_resp_genfifo_wdata_bo,
        input  cmd_resp_genfifo_ack_i
    );
endinterface

// File: rtl/citadel_gen.sv
// rtl/citadel_gen.sv - command-driven 4-operand compute engine with 2-stage result pipeline
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   cmd    - citadel_gen_if.slave: command in (req/rdata/ack), response out (req/wdata/ack)
// Command word {exec, addr, wdata}: exec 0 = READ, 1 = WRITE, other = NOP.
module citadel_gen (
    input  logic            clk_i,
    input  logic            rst_i,
    citadel_gen_if.slave    cmd
);

    logic [31:0] exec;
    logic [31:0] addr;
    logic [31:0] wdata;

    assign exec  = cmd.cmd_req_genfifo_rdata_bi[95:64];
    assign addr  = cmd.cmd_req_genfifo_rdata_bi[63:32];
    assign wdata = cmd.cmd_req_genfifo_rdata_bi[31:0];

    logic [31:0] in_reg [4];

    logic [31:0] p01, p23, s01, s23, m01, m23, x_st1;
    logic [31:0] r_dot, r_sum, r_max, r_xor;

    logic [1:0]  busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    logic        accept;
    logic        is_read;
    logic        is_write;
    logic [31:0] read_sel;

    // Only addr[2:0] selects anything; the upper bits are don't-care.
    logic        unused_addr;
    assign unused_addr = ^addr[31:3];

    // Busy and a pending response both hold the host off; the single
    // response slot is not freed until the edge that consumes it.
    assign cmd.cmd_req_genfifo_ack_o = cmd.cmd_req_genfifo_req_i & ~rst_i
                                     & (busy == 2'd0) & ~resp_valid;
    assign accept   = cmd.cmd_req_genfifo_ack_o;
    assign is_read  = (exec == 32'd0);
    assign is_write = (exec == 32'd1);

    always_comb begin
        read_sel = 32'd0;
        case (addr[2:0])
            3'd0: read_sel = r_dot;
            3'd1: read_sel = r_sum;
            3'd2: read_sel = r_max;
            3'd3: read_sel = r_xor;
            3'd4: read_sel = in_reg[0];
            3'd5: read_sel = in_reg[1];
            3'd6: read_sel = in_reg[2];
            default: read_sel = in_reg[3];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) in_reg[i] <= 32'd0;
            p01 <= 32'd0; p23 <= 32'd0;
            s01 <= 32'd0; s23 <= 32'd0;
            m01 <= 32'd0; m23 <= 32'd0;
            x_st1 <= 32'd0;
            r_dot <= 32'd0; r_sum <= 32'd0; r_max <= 32'd0; r_xor <= 32'd0;
            busy       <= 2'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
        end else begin
            // Stage 1: pairwise partials
            p01   <= in_reg[0] * in_reg[1];
            p23   <= in_reg[2] * in_reg[3];
            s01   <= in_reg[0] + in_reg[1];
            s23   <= in_reg[2] + in_reg[3];
            m01   <= (in_reg[0] > in_reg[1]) ? in_reg[0] : in_reg[1];
            m23   <= (in_reg[2] > in_reg[3]) ? in_reg[2] : in_reg[3];
            x_st1 <= in_reg[0] ^ in_reg[1] ^ in_reg[2] ^ in_reg[3];

            // Stage 2: combine pairs
            r_dot <= p01 + p23;
            r_sum <= s01 + s23;
            r_max <= (m01 > m23) ? m01 : m23;
            r_xor <= x_st1;

            // Two busy cycles cover the two pipeline stages, so a READ
            // accepted after a WRITE always sees the updated results.
            if (accept && is_write) begin
                in_reg[addr[1:0]] <= wdata;
                busy <= 2'd2;
            end else if (busy != 2'd0) begin
                busy <= busy - 2'd1;
            end

            // Gating on resp_valid keeps an X ack from touching the slot when idle.
            if (accept && is_read) begin
                resp_valid <= 1'b1;
                resp_data  <= read_sel;
            end else if (resp_valid && cmd.cmd_resp_genfifo_ack_i) begin
                resp_valid <= 1'b0;
            end
        end
    end

    assign cmd.cmd_resp_genfifo_req_o    = resp_valid;
    assign cmd.cmd_resp_genfifo_wdata_bo = resp_data;

endmodule

// File: tb/tb_citadel_gen.sv
// tb/tb_citadel_gen.sv - randomized self-checking bench for citadel_gen
module tb_citadel_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    citadel_gen_if bus ();

    citadel_gen dut (
        .clk_i (clk),
        .rst_i (rst),
        .cmd   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl_in [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: results derived directly from the operand set.
    function automatic logic [31:0] model_val(input logic [2:0] a);
        logic [31:0] v;
        case (a)
            3'd0: v = mdl_in[0] * mdl_in[1] + mdl_in[2] * mdl_in[3];
            3'd1: v = mdl_in[0] + mdl_in[1] + mdl_in[2] + mdl_in[3];
            3'd2: begin
                v = mdl_in[0];
                for (int i = 1; i < 4; i++) if (mdl_in[i] > v) v = mdl_in[i];
            end
            3'd3: v = mdl_in[0] ^ mdl_in[1] ^ mdl_in[2] ^ mdl_in[3];
            default: v = mdl_in[a - 3'd4];
        endcase
        return v;
    endfunction

    // Starts and ends just after a negedge. Returns cycles spent waiting for ack.
    task automatic send(input logic [31:0] ex, input logic [31:0] ad, input logic [31:0] wd,
                        output int waits);
        int n;
        n = 0;
        bus.cmd_req_genfifo_req_i    = 1'b1;
        bus.cmd_req_genfifo_rdata_bi = {ex, ad, wd};
        #1;
        while (bus.cmd_req_genfifo_ack_o !== 1'b1 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) check("cmd_ack_timeout", 32'd0, 32'd1);
        @(negedge clk); #1;
        bus.cmd_req_genfifo_req_i = 1'b0;
        waits = n;
        if (ex == 32'd1) mdl_in[ad[1:0]] = wd;
    endtask

    task automatic do_read(input logic [31:0] ad, input int hold, input string tag);
        int w;
        logic [31:0] exp;
        exp = model_val(ad[2:0]);
        send(32'd0, ad, 32'd0, w);
        check({tag, "_req"}, {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
        check({tag, "_data"}, bus.cmd_resp_genfifo_wdata_bo, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            check({tag, "_hold_req"}, {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
            check({tag, "_hold_data"}, bus.cmd_resp_genfifo_wdata_bo, exp);
        end
        bus.cmd_resp_genfifo_ack_i = 1'b1;
        @(negedge clk); #1;
        bus.cmd_resp_genfifo_ack_i = 1'b0;
        check({tag, "_drop"}, {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
        check({tag, "_data_kept"}, bus.cmd_resp_genfifo_wdata_bo, exp);
    endtask

    initial begin
        int w;
        logic [31:0] ex, ad, wd;
        bit prev_write;

        for (int i = 0; i < 4; i++) mdl_in[i] = 32'd0;
        bus.cmd_req_genfifo_req_i    = 1'b0;
        bus.cmd_req_genfifo_rdata_bi = 96'd0;
        bus.cmd_resp_genfifo_ack_i   = 1'bx;
        repeat (2) @(negedge clk);
        #1;
        check("ack_in_reset", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
        rst = 1'b0;

        // Idle: nothing moves, undriven response ack is harmless
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            check("idle_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
            check("idle_resp_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
            check("idle_resp_data", bus.cmd_resp_genfifo_wdata_bo, 32'd0);
        end
        bus.cmd_resp_genfifo_ack_i = 1'b0;

        // Two back-to-back all-zero commands
        send(32'd0, 32'd0, 32'd0, w);
        check("b2b_first_wait", w, 32'd0);
        check("b2b_first_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
        check("b2b_first_data", bus.cmd_resp_genfifo_wdata_bo, 32'd0);
        bus.cmd_req_genfifo_req_i    = 1'b1;
        bus.cmd_req_genfifo_rdata_bi = 96'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("b2b_blocked", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
            @(negedge clk); #1;
        end
        bus.cmd_resp_genfifo_ack_i = 1'b1;
        #1;
        check("b2b_blocked_on_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
        @(negedge clk); #1;
        bus.cmd_resp_genfifo_ack_i = 1'b0;
        check("b2b_slot_free_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
        check("b2b_second_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd1);
        @(negedge clk); #1;
        bus.cmd_req_genfifo_req_i = 1'b0;
        check("b2b_second_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
        check("b2b_second_data", bus.cmd_resp_genfifo_wdata_bo, 32'd0);
        bus.cmd_resp_genfifo_ack_i = 1'b1;
        @(negedge clk); #1;
        bus.cmd_resp_genfifo_ack_i = 1'b0;

        // Directed operand set 3,5,7,11 (busy gap of 2 after each WRITE)
        send(32'd1, 32'd0, 32'd3, w);
        send(32'd1, 32'd1, 32'd5, w);  check("busy_gap_w1", w, 32'd2);
        send(32'd1, 32'd2, 32'd7, w);  check("busy_gap_w2", w, 32'd2);
        send(32'd1, 32'hFFFF_FFF3, 32'd11, w); check("busy_gap_w3", w, 32'd2);
        check("dir_dot_model", model_val(3'd0), 32'd92);
        do_read(32'd0, 0, "dir_r0");
        do_read(32'd1, 0, "dir_r1");
        do_read(32'd2, 0, "dir_r2");
        do_read(32'd3, 0, "dir_r3");
        do_read(32'hABCD_0007, 0, "dir_in3");

        // Wrap and unsigned max
        send(32'd1, 32'd0, 32'hFFFF_FFFF, w);
        send(32'd1, 32'd1, 32'd2, w);
        send(32'd1, 32'd2, 32'd0, w);
        send(32'd1, 32'd3, 32'd0, w);
        check("wrap_dot_model", model_val(3'd0), 32'hFFFF_FFFE);
        do_read(32'd0, 0, "wrap_r0");
        do_read(32'd1, 0, "wrap_r1");
        do_read(32'd2, 0, "wrap_r2");

        // Long hold with command pressure
        send(32'd0, 32'd4, 32'd0, w);
        bus.cmd_req_genfifo_req_i    = 1'b1;
        bus.cmd_req_genfifo_rdata_bi = {32'd0, 32'd5, 32'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("hold_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
            check("hold_data", bus.cmd_resp_genfifo_wdata_bo, 32'hFFFF_FFFF);
            check("hold_cmd_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
        end
        bus.cmd_resp_genfifo_ack_i = 1'b1;
        @(negedge clk); #1;
        bus.cmd_resp_genfifo_ack_i = 1'b0;
        check("hold_drop", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
        check("hold_next_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd1);
        @(negedge clk); #1;
        bus.cmd_req_genfifo_req_i = 1'b0;
        check("hold_next_data", bus.cmd_resp_genfifo_wdata_bo, 32'd2);
        bus.cmd_resp_genfifo_ack_i = 1'b1;
        @(negedge clk); #1;
        bus.cmd_resp_genfifo_ack_i = 1'b0;

        // NOP: accepted, no response, no busy
        send(32'd5, 32'd1, 32'h1234_5678, w);
        check("nop_wait", w, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("nop_no_resp", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
        end
        do_read(32'd5, 0, "nop_in1_kept");

        // Randomized mix
        prev_write = 1'b0;
        for (int k = 0; k < 60; k++) begin
            int kind;
            kind = $urandom_range(0, 9);
            ad = $urandom;
            case ($urandom_range(0, 3))
                0: wd = 32'hFFFF_FFFF;
                1: wd = 32'h8000_0000 | ($urandom & 32'hFF);
                default: wd = $urandom;
            endcase
            if (kind < 4) begin
                send(32'd1, ad, wd, w);
                if (prev_write) check("rnd_busy_gap", w, 32'd2);
                else            check("rnd_write_wait", w, 32'd0);
                prev_write = 1'b1;
            end else if (kind < 9) begin
                if (prev_write) begin
                    // Pipeline settles during the busy window
                    repeat (2) @(negedge clk);
                    #1;
                end
                do_read(ad, $urandom_range(0, 3), "rnd_read");
                prev_write = 1'b0;
            end else begin
                ex = $urandom_range(2, 32'hFFFF);
                if (prev_write) begin
                    repeat (2) @(negedge clk);
                    #1;
                end
                send(ex, ad, wd, w);
                check("rnd_nop_wait", w, 32'd0);
                prev_write = 1'b0;
            end
        end
        if (prev_write) begin
            repeat (2) @(negedge clk);
            #1;
        end

        // Reset while a response is pending, with a WRITE presented during reset
        send(32'd0, 32'd1, 32'd0, w);
        check("pre_rst_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd1);
        rst = 1'b1;
        bus.cmd_req_genfifo_req_i    = 1'b1;
        bus.cmd_req_genfifo_rdata_bi = {32'd1, 32'd2, 32'hDEAD_BEEF};
        #1;
        check("rst_cmd_ack", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
        @(negedge clk); #1;
        check("rst_resp_req", {31'd0, bus.cmd_resp_genfifo_req_o}, 32'd0);
        check("rst_resp_data", bus.cmd_resp_genfifo_wdata_bo, 32'd0);
        check("rst_cmd_ack2", {31'd0, bus.cmd_req_genfifo_ack_o}, 32'd0);
        bus.cmd_req_genfifo_req_i = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mdl_in[i] = 32'd0;
        @(negedge clk); #1;
        for (int a = 0; a < 8; a++) do_read(a, 0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
